// File: rtl/burst_read_buffer.sv
// burst_read_buffer: accepts one 64-bit line read from a client, issues a
// single 4-word x 16-bit burst read on the memory port, and reassembles the
// returned words into the line {w3,w2,w1,w0}.
// Optional feature: define BURST_READ_BUFFER_HIT_EN to add a one-entry line
// tag so a repeat read of the last fetched line completes without a burst.
module burst_read_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_rd,
    input  logic [31:0] io_in_addr,
    output logic        io_in_wait_n,
    output logic        io_in_valid,
    output logic [63:0] io_in_dout,
    output logic        io_out_rd,
    output logic [24:0] io_out_addr,
    input  logic        io_out_wait_n,
    input  logic        io_out_valid,
    input  logic [15:0] io_out_dout,
    input  logic        io_out_burstDone
);

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, DONE} state_t;

    state_t          state;
    logic [21:0]     line_addr;   // addrReg[24:3]; the low 3 bits are always zero
    logic [2:0]      cnt;         // saturates at 4 so extra words are dropped
    logic [3:0][15:0] words;
    logic            hit;

    // Byte-offset and high address bits carry no meaning for a line fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{io_in_addr[31:25], io_in_addr[2:0]};

`ifdef BURST_READ_BUFFER_HIT_EN
    logic [21:0] tag;
    logic        tag_valid;

    // In DONE the line just assembled is already usable, so compare against
    // the live address register rather than the tag that is being written.
    always_comb begin
        hit = 1'b0;
        if (state == DONE)
            hit = (io_in_addr[24:3] == line_addr);
        else
            hit = tag_valid && (io_in_addr[24:3] == tag);
    end

    // Tag captures the completed line on every DONE; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag       <= '0;
            tag_valid <= 1'b0;
        end else if (state == DONE) begin
            tag       <= line_addr;
            tag_valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign io_out_addr = {line_addr, 3'b000};
    assign io_in_dout  = words;

    // Main FSM; handshake outputs are registered alongside the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            line_addr    <= '0;
            cnt          <= '0;
            words        <= '0;
            io_in_wait_n <= 1'b1;
            io_in_valid  <= 1'b0;
            io_out_rd    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    io_in_valid <= 1'b0;
                    if (io_in_rd) begin
                        line_addr <= io_in_addr[24:3];
                        cnt       <= '0;
                        if (hit) begin
                            state        <= DONE;
                            io_in_valid  <= 1'b1;
                            io_in_wait_n <= 1'b1;
                            io_out_rd    <= 1'b0;
                        end else begin
                            state        <= REQ;
                            io_in_wait_n <= 1'b0;
                            io_out_rd    <= 1'b1;
                        end
                    end else begin
                        state        <= IDLE;
                        io_in_wait_n <= 1'b1;
                        io_out_rd    <= 1'b0;
                    end
                end
                REQ: begin
                    // Memory never returns data in the acceptance cycle.
                    if (io_out_wait_n) begin
                        state     <= COLLECT;
                        io_out_rd <= 1'b0;
                    end
                end
                COLLECT: begin
                    // A word coinciding with burstDone is stored before leaving.
                    if (io_out_valid && (cnt < 3'd4)) begin
                        words[cnt[1:0]] <= io_out_dout;
                        cnt             <= cnt + 3'd1;
                    end
                    if (io_out_burstDone) begin
                        state        <= DONE;
                        io_in_valid  <= 1'b1;
                        io_in_wait_n <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    io_in_wait_n <= 1'b1;
                    io_in_valid  <= 1'b0;
                    io_out_rd    <= 1'b0;
                end
            endcase
        end
    end

endmodule
